// File: rtl/dkong_obj_dma.sv
// Vblank-synchronised sprite-table DMA: copies LEN bytes from Z80 work RAM into object RAM.
// Define OBJ_DMA_AUTO_EN to keep the block armed after the first arm_wr (one transfer every frame).
module dkong_obj_dma #(
  parameter int          LEN      = 384,
  parameter int          RD_WAIT  = 2,
  parameter logic [9:0]  OBJ_BASE = 10'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arm_wr,
  input  logic [15:0] arm_src,
  input  logic        vblk,
  output logic        busrq_n,
  input  logic        busak_n,
  output logic [15:0] mem_addr,
  output logic        mem_rdn,
  input  logic [7:0]  mem_data,
  output logic [9:0]  obj_addr,
  output logic [7:0]  obj_data,
  output logic        obj_we,
  input  logic        vram_busy,
  output logic        dma_active,
  output logic        done
);

  localparam int             WW        = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [WW-1:0]  WAIT_LAST = WW'(RD_WAIT - 1);
  localparam logic [9:0]     LAST      = 10'(LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RD, S_WR, S_REL} state_t;

  state_t          state;
  logic [15:0]     src;
  logic            armed;
  logic            vblk_q;
  logic [9:0]      count;
  logic [WW-1:0]   wait_cnt;
  logic            vblk_rise;
  logic            start;

  assign vblk_rise = vblk & ~vblk_q;
  // An arm_wr landing in the same cycle as the vblank edge still counts.
  assign start     = vblk_rise & (armed | arm_wr);

  // The object-RAM port is writable in the very cycle vram_busy is low, so the
  // write strobe is gated combinationally; address and data are already registered.
  assign obj_we = (state == S_WR) & ~vram_busy;

  // NOTE: every state register below uses <= so all of them update from the
  // same pre-edge values; a blocking = here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      src        <= '0;
      armed      <= 1'b0;
      vblk_q     <= 1'b0;
      count      <= '0;
      wait_cnt   <= '0;
      busrq_n    <= 1'b1;
      mem_addr   <= '0;
      mem_rdn    <= 1'b1;
      obj_addr   <= OBJ_BASE;
      obj_data   <= '0;
      dma_active <= 1'b0;
      done       <= 1'b0;
    end else begin
      vblk_q <= vblk;
      done   <= 1'b0;

      if (arm_wr) begin
        src   <= arm_src;
        armed <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_REQ;
            busrq_n    <= 1'b0;
            dma_active <= 1'b1;
`ifndef OBJ_DMA_AUTO_EN
            armed      <= 1'b0;
`endif
          end
        end

        S_REQ: begin
          if (!busak_n) begin
            state    <= S_RD;
            mem_addr <= src;
            count    <= '0;
            wait_cnt <= '0;
            mem_rdn  <= 1'b0;
          end
        end

        S_RD: begin
          if (wait_cnt == WAIT_LAST) begin
            state    <= S_WR;
            obj_data <= mem_data;
            obj_addr <= OBJ_BASE + count;
            mem_rdn  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_WR: begin
          if (!vram_busy) begin
            count    <= count + 1'b1;
            mem_addr <= mem_addr + 16'd1;
            if (count == LAST) begin
              state   <= S_REL;
              busrq_n <= 1'b1;
              done    <= 1'b1;
            end else begin
              state    <= S_RD;
              wait_cnt <= '0;
              mem_rdn  <= 1'b0;
            end
          end
        end

        S_REL: begin
          state      <= S_IDLE;
          dma_active <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dkong_obj_dma.sv
// Directed bench for dkong_obj_dma: a bus model acks two cycles after busrq_n, a monitor tallies writes.
`timescale 1ns/1ps
module tb_dkong_obj_dma;

  logic        clk = 1'b0, rst_n = 1'b0, arm_wr = 1'b0, vblk = 1'b0;
  logic        busak_n = 1'b1, vram_busy = 1'b0;
  logic [15:0] arm_src = '0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data, obj_data;
  logic [9:0]  obj_addr;
  logic        busrq_n, mem_rdn, obj_we, dma_active, done;

  int n_cmp = 0, n_bad = 0;

  // monitor tallies (only the monitor writes these)
  int tot_we = 0, bad_addr = 0, bad_data = 0, bad_rd = 0, busy_viol = 0;
  int done_cnt = 0, rq_low_cnt = 0, active_cnt = 0, xfer_wr = 0, xfer_rd = 0;
  logic        act_q = 1'b0, rdn_q = 1'b1;
  logic [15:0] rd_log [32];
  logic [15:0] exp_src = '0;
  logic [1:0]  ack_pipe = 2'b11;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  assign mem_data = pat(mem_addr);

  dkong_obj_dma dut (
    .clk(clk), .rst_n(rst_n), .arm_wr(arm_wr), .arm_src(arm_src), .vblk(vblk),
    .busrq_n(busrq_n), .busak_n(busak_n), .mem_addr(mem_addr), .mem_rdn(mem_rdn),
    .mem_data(mem_data), .obj_addr(obj_addr), .obj_data(obj_data), .obj_we(obj_we),
    .vram_busy(vram_busy), .dma_active(dma_active), .done(done)
  );

  always #5 clk = ~clk;

  // Z80 model: busak_n follows busrq_n two cycles later.
  initial forever begin
    @(posedge clk);
    #1;
    busak_n  = ack_pipe[1];
    ack_pipe = {ack_pipe[0], busrq_n};
  end

  initial forever begin
    @(negedge clk);
    if (dma_active && !act_q) begin xfer_wr = 0; xfer_rd = 0; end
    if (dma_active) active_cnt++;
    if (!busrq_n) rq_low_cnt++;
    if (done) done_cnt++;
    if (dma_active && !mem_rdn && rdn_q) begin
      if (mem_addr !== 16'(exp_src + xfer_rd)) bad_rd++;
      if (xfer_rd < 32) rd_log[xfer_rd] = mem_addr;
      xfer_rd++;
    end
    if (obj_we) begin
      if (obj_addr !== 10'(xfer_wr)) bad_addr++;
      if (obj_data !== pat(16'(exp_src + xfer_wr))) bad_data++;
      if (vram_busy) busy_viol++;
      xfer_wr++;
      tot_we++;
    end
    act_q = dma_active;
    rdn_q = mem_rdn;
  end

  task automatic do_arm(input logic [15:0] s);
    @(posedge clk); #1 arm_wr = 1'b1; arm_src = s;
    @(posedge clk); #1 arm_wr = 1'b0;
  endtask

  task automatic start_frame();
    @(posedge clk); #1 vblk = 1'b1;
    repeat (4) @(posedge clk);
    #1 vblk = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    n_cmp++; if (busrq_n !== 1'b1) begin n_bad++; $display("FAIL reset_busrq_n: got %b want 1", busrq_n); end
    n_cmp++; if (mem_rdn !== 1'b1) begin n_bad++; $display("FAIL reset_mem_rdn: got %b want 1", mem_rdn); end
    n_cmp++; if ({obj_we, dma_active, done} !== 3'b000) begin n_bad++; $display("FAIL reset_strobes: got %b want 000", {obj_we, dma_active, done}); end
    n_cmp++; if (mem_addr !== 16'h0000) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
    n_cmp++; if (obj_addr !== 10'h000) begin n_bad++; $display("FAIL reset_obj_addr: got %h want 000", obj_addr); end
    n_cmp++; if (obj_data !== 8'h00) begin n_bad++; $display("FAIL reset_obj_data: got %h want 00", obj_data); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({busrq_n, dma_active} !== 2'b10) begin n_bad++; $display("FAIL post_reset_idle: got %b want 10", {busrq_n, dma_active}); end
  endtask

  task automatic test_no_arm();
    int rq0 = rq_low_cnt, we0 = tot_we, d0 = done_cnt;
    start_frame();
    repeat (300) @(negedge clk);
    n_cmp++; if (rq_low_cnt - rq0 !== 0) begin n_bad++; $display("FAIL no_arm_busrq: got %0d low cycles want 0", rq_low_cnt - rq0); end
    n_cmp++; if (tot_we - we0 !== 0) begin n_bad++; $display("FAIL no_arm_we: got %0d writes want 0", tot_we - we0); end
    n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL no_arm_done: got %0d want 0", done_cnt - d0); end
  endtask

  task automatic test_basic();
    int ba0 = bad_addr, bd0 = bad_data, br0 = bad_rd, d0 = done_cnt, a0 = active_cnt;
    bit got;
    exp_src = 16'h6900;
    do_arm(16'h6900);
    vblk = 1'b1;
    @(negedge clk);
    n_cmp++; if (busrq_n !== 1'b1) begin n_bad++; $display("FAIL basic_busrq_early: got %b want 1", busrq_n); end
    @(negedge clk);
    n_cmp++; if ({busrq_n, dma_active} !== 2'b01) begin n_bad++; $display("FAIL basic_req_latency: got %b want 01", {busrq_n, dma_active}); end
    repeat (3) @(posedge clk);
    #1 vblk = 1'b0;
    wait_done(2000, got);
    repeat (3) @(negedge clk);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL basic_done_timeout: got %b want 1", got); end
    n_cmp++; if (xfer_wr !== 384) begin n_bad++; $display("FAIL basic_writes: got %0d want 384", xfer_wr); end
    n_cmp++; if (bad_addr - ba0 !== 0) begin n_bad++; $display("FAIL basic_obj_addr: got %0d bad want 0", bad_addr - ba0); end
    n_cmp++; if (bad_data - bd0 !== 0) begin n_bad++; $display("FAIL basic_obj_data: got %0d bad want 0", bad_data - bd0); end
    n_cmp++; if (bad_rd - br0 !== 0) begin n_bad++; $display("FAIL basic_mem_addr: got %0d bad want 0", bad_rd - br0); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (active_cnt - a0 !== 1156) begin n_bad++; $display("FAIL basic_active_cycles: got %0d want 1156", active_cnt - a0); end
    n_cmp++; if ({busrq_n, dma_active} !== 2'b10) begin n_bad++; $display("FAIL basic_release: got %b want 10", {busrq_n, dma_active}); end
  endtask

  task automatic test_vram_busy();
    int bd0 = bad_data, ba0 = bad_addr, bv0 = busy_viol, d0 = done_cnt, a0 = active_cnt;
    bit got = 1'b0;
    exp_src = 16'h2A10;
    do_arm(16'h2A10);
    vblk = 1'b1;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(posedge clk); #1;
      vram_busy = ~vram_busy;
      if (i == 4) vblk = 1'b0;
      if (done === 1'b1) got = 1'b1;
    end
    vram_busy = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL busy_done_timeout: got %b want 1", got); end
    n_cmp++; if (xfer_wr !== 384) begin n_bad++; $display("FAIL busy_writes: got %0d want 384", xfer_wr); end
    n_cmp++; if (busy_viol - bv0 !== 0) begin n_bad++; $display("FAIL busy_we_while_busy: got %0d want 0", busy_viol - bv0); end
    n_cmp++; if ((bad_data - bd0) + (bad_addr - ba0) !== 0) begin n_bad++; $display("FAIL busy_data_addr: got %0d bad want 0", (bad_data - bd0) + (bad_addr - ba0)); end
    n_cmp++; if ((active_cnt - a0 >= 1539) !== 1'b1) begin n_bad++; $display("FAIL busy_stalls: got %0d active cycles want >=1539", active_cnt - a0); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL busy_done_count: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_wrap();
    int br0 = bad_rd, bd0 = bad_data;
    bit got;
    exp_src = 16'hFFF0;
    do_arm(16'hFFF0);
    start_frame();
    wait_done(2000, got);
    repeat (3) @(negedge clk);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL wrap_done_timeout: got %b want 1", got); end
    n_cmp++; if (rd_log[15] !== 16'hFFFF) begin n_bad++; $display("FAIL wrap_addr15: got %h want FFFF", rd_log[15]); end
    n_cmp++; if (rd_log[16] !== 16'h0000) begin n_bad++; $display("FAIL wrap_addr16: got %h want 0000", rd_log[16]); end
    n_cmp++; if (rd_log[31] !== 16'h000F) begin n_bad++; $display("FAIL wrap_addr31: got %h want 000F", rd_log[31]); end
    n_cmp++; if ((bad_rd - br0) + (bad_data - bd0) !== 0) begin n_bad++; $display("FAIL wrap_sequence: got %0d bad want 0", (bad_rd - br0) + (bad_data - bd0)); end
  endtask

  task automatic test_simultaneous();
    int bd0 = bad_data;
    bit got;
    do_arm(16'h1000);
    exp_src = 16'h2000;
    @(posedge clk); #1 arm_wr = 1'b1; arm_src = 16'h2000; vblk = 1'b1;
    @(posedge clk); #1 arm_wr = 1'b0;
    repeat (3) @(posedge clk);
    #1 vblk = 1'b0;
    wait_done(2000, got);
    repeat (3) @(negedge clk);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL simul_done_timeout: got %b want 1", got); end
    n_cmp++; if (rd_log[0] !== 16'h2000) begin n_bad++; $display("FAIL simul_src: got %h want 2000", rd_log[0]); end
    n_cmp++; if (bad_data - bd0 !== 0) begin n_bad++; $display("FAIL simul_data: got %0d bad want 0", bad_data - bd0); end
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt, ba0 = bad_addr;
    bit got = 1'b0, hit = 1'b0;
    exp_src = 16'h4000;
    do_arm(16'h4000);
    start_frame();
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (xfer_wr >= 100) hit = 1'b1;
    end
    n_cmp++; if ({hit, busrq_n} !== 2'b10) begin n_bad++; $display("FAIL mid_reached_100: got %b want 10", {hit, busrq_n}); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({busrq_n, obj_we, dma_active, mem_rdn} !== 4'b1001) begin n_bad++; $display("FAIL mid_async_abort: got %b want 1001", {busrq_n, obj_we, dma_active, mem_rdn}); end
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL mid_no_done: got %0d want 0", done_cnt - d0); end
    do_arm(16'h4000);
    start_frame();
    wait_done(2000, got);
    repeat (3) @(negedge clk);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL mid_restart_timeout: got %b want 1", got); end
    n_cmp++; if (xfer_wr !== 384) begin n_bad++; $display("FAIL mid_restart_writes: got %0d want 384", xfer_wr); end
    n_cmp++; if (bad_addr - ba0 !== 0) begin n_bad++; $display("FAIL mid_restart_obj_addr: got %0d bad want 0", bad_addr - ba0); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL mid_restart_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_second_vblk();
    int rq0 = rq_low_cnt, we0 = tot_we, bd0 = bad_data;
    bit got;
    start_frame();
`ifdef OBJ_DMA_AUTO_EN
    wait_done(2000, got);
    repeat (3) @(negedge clk);
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL auto_repeat_timeout: got %b want 1", got); end
    n_cmp++; if (tot_we - we0 !== 384) begin n_bad++; $display("FAIL auto_repeat_writes: got %0d want 384", tot_we - we0); end
    n_cmp++; if (bad_data - bd0 !== 0) begin n_bad++; $display("FAIL auto_repeat_data: got %0d bad want 0", bad_data - bd0); end
`else
    got = 1'b0;
    repeat (300) @(negedge clk);
    n_cmp++; if (rq_low_cnt - rq0 !== 0) begin n_bad++; $display("FAIL oneshot_busrq: got %0d low cycles want 0", rq_low_cnt - rq0); end
    n_cmp++; if (tot_we - we0 !== 0) begin n_bad++; $display("FAIL oneshot_writes: got %0d want 0", tot_we - we0); end
    n_cmp++; if (bad_data - bd0 !== 0) begin n_bad++; $display("FAIL oneshot_data: got %0d bad want 0", bad_data - bd0); end
`endif
  endtask

  initial begin
    test_reset();
    test_no_arm();
    test_basic();
    test_vram_busy();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    test_second_vblk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
